// File: rtl/hazard_control_unit.sv
// Decode-side hazard controller: load-use stalls, taken-jump flush windows and
// saturating stall/flush statistics. Control outputs are combinational from state and inputs.
module hazard_control_unit #(
   parameter int REG_W             = 3,
   parameter int CCR_W             = 4,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CCR_W-1:0] ccr,
   input  logic             jmpUncond,
   input  logic [1:0]       jmpCond,
   input  logic [REG_W-1:0] src1,
   input  logic             src1Valid,
   input  logic [REG_W-1:0] src2,
   input  logic             src2Valid,
   input  logic [REG_W-1:0] exDst,
   input  logic             exMemRead,
   output logic [1:0]       pcSrc,
   output logic             stallD,
   output logic             bubbleE,
   output logic             flushF,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   localparam int MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
   localparam int CW      = $clog2(MAX_CYC) + 1;
   localparam logic [CW-1:0]    STALL_INIT = CW'(LOAD_STALL_CYCLES - 1);
   localparam logic [CW-1:0]    FLUSH_INIT = CW'(FLUSH_CYCLES - 1);
   localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
   localparam logic [CNT_W-1:0] STAT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] STAT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } state_t;

   state_t        state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic          load_use_s, cond_taken_s, taken_s, jump_acc_s;
   logic [1:0]    pc_src_s;
   logic          stall_s, bubble_s, flush_s;
   logic          unused_ccr_s;

   // The O flag does not steer any jump; fold it away explicitly.
   assign unused_ccr_s = ^ccr;

   // Hazard and branch-condition decode.
   always_comb begin
      load_use_s   = exMemRead & ((src1Valid & (src1 == exDst)) | (src2Valid & (src2 == exDst)));
      cond_taken_s = ((jmpCond == 2'b01) & ccr[0]) |
                     ((jmpCond == 2'b10) & ccr[3]) |
                     ((jmpCond == 2'b11) & ccr[1]);
      taken_s      = jmpUncond | cond_taken_s;
   end

   // Next-state and raw control decode; load-use outranks jumps since flags may be stale.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      pc_src_s    = 2'b00;
      stall_s     = 1'b0;
      bubble_s    = 1'b0;
      flush_s     = 1'b0;
      jump_acc_s  = 1'b0;
      case (state_r)
         RUN: begin
            if (load_use_s) begin
               pc_src_s = 2'b10;
               stall_s  = 1'b1;
               bubble_s = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_nxt_s = STALL;
                  cnt_nxt_s   = STALL_INIT;
               end else begin
                  state_nxt_s = RUN;
               end
            end else if (taken_s) begin
               pc_src_s   = 2'b01;
               flush_s    = 1'b1;
               jump_acc_s = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt_s = FLUSH;
                  cnt_nxt_s   = FLUSH_INIT;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               state_nxt_s = RUN;
            end
         end
         STALL: begin
            pc_src_s  = 2'b10;
            stall_s   = 1'b1;
            bubble_s  = 1'b1;
            cnt_nxt_s = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = STALL;
            end
         end
         FLUSH: begin
            flush_s   = 1'b1;
            cnt_nxt_s = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = FLUSH;
            end
         end
         default: begin
            state_nxt_s = RUN;
            cnt_nxt_s   = {CW{1'b0}};
         end
      endcase
   end

   // Reset forces quiet outputs immediately, independent of the clock.
   always_comb begin
      if (rst) begin
         pcSrc   = pc_src_s;
         stallD  = stall_s;
         bubbleE = bubble_s;
         flushF  = flush_s;
      end else begin
         pcSrc   = 2'b00;
         stallD  = 1'b0;
         bubbleE = 1'b0;
         flushF  = 1'b0;
      end
   end

   // State and window counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= RUN;
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Saturating statistics: bubble cycles and accepted jumps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCount <= {CNT_W{1'b0}};
         flushCount <= {CNT_W{1'b0}};
      end else begin
         if (bubble_s && (stallCount != STAT_MAX)) begin
            stallCount <= stallCount + STAT_ONE;
         end
         if (jump_acc_s && (flushCount != STAT_MAX)) begin
            flushCount <= flushCount + STAT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: three parameterisations driven by
// directed vectors, expectations queued at issue and checked by a monitor at negedge.
module tb_hazard_control_unit;

   typedef struct packed {
      logic [3:0] ccr;
      logic       ju;
      logic [1:0] jc;
      logic [2:0] s1;
      logic       v1;
      logic [2:0] s2;
      logic       v2;
      logic [2:0] ed;
      logic       mr;
   } stim_t;

   typedef struct {
      int          dut;
      int          tag;
      logic [1:0]  pc;
      logic        s;
      logic        b;
      logic        f;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
   stim_t in_a = '0, in_b = '0, in_c = '0;

   logic [1:0]  a_pc, b_pc, c_pc;
   logic        a_s, a_b, a_f, b_s, b_b, b_f, c_s, c_b, c_f;
   logic [15:0] a_sc, a_fc;
   logic [1:0]  b_sc, b_fc, c_sc, c_fc;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   int   step_no = 0;

   always #5 clk = ~clk;

   hazard_control_unit u_a (
      .clk(clk), .rst(rst_a), .ccr(in_a.ccr), .jmpUncond(in_a.ju), .jmpCond(in_a.jc),
      .src1(in_a.s1), .src1Valid(in_a.v1), .src2(in_a.s2), .src2Valid(in_a.v2),
      .exDst(in_a.ed), .exMemRead(in_a.mr), .pcSrc(a_pc), .stallD(a_s), .bubbleE(a_b),
      .flushF(a_f), .stallCount(a_sc), .flushCount(a_fc));

   hazard_control_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst_b), .ccr(in_b.ccr), .jmpUncond(in_b.ju), .jmpCond(in_b.jc),
      .src1(in_b.s1), .src1Valid(in_b.v1), .src2(in_b.s2), .src2Valid(in_b.v2),
      .exDst(in_b.ed), .exMemRead(in_b.mr), .pcSrc(b_pc), .stallD(b_s), .bubbleE(b_b),
      .flushF(b_f), .stallCount(b_sc), .flushCount(b_fc));

   hazard_control_unit #(.CNT_W(2)) u_c (
      .clk(clk), .rst(rst_c), .ccr(in_c.ccr), .jmpUncond(in_c.ju), .jmpCond(in_c.jc),
      .src1(in_c.s1), .src1Valid(in_c.v1), .src2(in_c.s2), .src2Valid(in_c.v2),
      .exDst(in_c.ed), .exMemRead(in_c.mr), .pcSrc(c_pc), .stallD(c_s), .bubbleE(c_b),
      .flushF(c_f), .stallCount(c_sc), .flushCount(c_fc));

   function automatic stim_t mk(input logic [3:0] ccr, input logic ju, input logic [1:0] jc,
                                input logic [2:0] s1, input logic v1, input logic [2:0] s2,
                                input logic v2, input logic [2:0] ed, input logic mr);
      stim_t st;
      st.ccr = ccr; st.ju = ju; st.jc = jc; st.s1 = s1; st.v1 = v1;
      st.s2 = s2; st.v2 = v2; st.ed = ed; st.mr = mr;
      return st;
   endfunction

   // Apply a vector to one DUT and queue the response it must show this cycle.
   task automatic drive(input int d, input stim_t st, input logic [1:0] pc,
                        input logic s, input logic b, input logic f, input int sc, input int fc);
      exp_t e;
      case (d)
         0: in_a = st;
         1: in_b = st;
         default: in_c = st;
      endcase
      e.dut = d; e.tag = step_no; e.pc = pc; e.s = s; e.b = b; e.f = f;
      e.sc = 16'(sc); e.fc = 16'(fc);
      q.push_back(e);
      step_no++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int d, input stim_t st, input logic [1:0] pc,
                       input logic s, input logic b, input logic f, input int sc, input int fc);
      drive(d, st, pc, s, b, f, sc, fc);
      tick();
   endtask

   // Monitor: outputs are valid every cycle; compare at the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [36:0] act_v, exp_v;
      if (q.size() > 0) begin
         e = q.pop_front();
         case (e.dut)
            0: act_v = {a_pc, a_s, a_b, a_f, a_sc, a_fc};
            1: act_v = {b_pc, b_s, b_b, b_f, 14'd0, b_sc, 14'd0, b_fc};
            default: act_v = {c_pc, c_s, c_b, c_f, 14'd0, c_sc, 14'd0, c_fc};
         endcase
         exp_v = {e.pc, e.s, e.b, e.f, e.sc, e.fc};
         checks++;
         if ((act_v[36:32] === exp_v[36:32]) &&
             (act_v[31:16] === exp_v[31:16]) &&
             (act_v[15:0]  === exp_v[15:0])) begin
            passed++;
         end else begin
            $display("FAIL dut%0d step%0d: got pc=%b stall=%b bubble=%b flush=%b sc=%0d fc=%0d, expected pc=%b stall=%b bubble=%b flush=%b sc=%0d fc=%0d",
                     e.dut, e.tag, act_v[36:35], act_v[34], act_v[33], act_v[32], act_v[31:16], act_v[15:0],
                     e.pc, e.s, e.b, e.f, e.sc, e.fc);
         end
      end
   end

   initial begin
      stim_t lu_a, lu_b, lu_c, idle;
      idle = '0;
      lu_a = mk(4'b0000, 1'b1, 2'b00, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
      lu_b = mk(4'b0000, 1'b0, 2'b00, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
      lu_c = mk(4'b0010, 1'b0, 2'b11, 3'd0, 1'b0, 3'd2, 1'b1, 3'd2, 1'b1);

      @(posedge clk);
      #1;
      // Reset held: a load-use present must not leak to the outputs.
      step(0, lu_a, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1, lu_b, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);
      step(2, lu_c, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);
      in_a = idle; in_b = idle; in_c = idle;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // DUT A: single-cycle stall and flush
      step(0, lu_a, 2'b10, 1'b1, 1'b1, 1'b0, 0, 0);
      step(0, idle, 2'b00, 1'b0, 1'b0, 1'b0, 1, 0);
      step(0, mk(4'b0000, 1'b1, 2'b00, 3'd3, 1'b0, 3'd3, 1'b0, 3'd3, 1'b1), 2'b01, 1'b0, 1'b0, 1'b1, 1, 0);
      step(0, idle, 2'b00, 1'b0, 1'b0, 1'b0, 1, 1);
      step(0, mk(4'b0000, 1'b0, 2'b00, 3'd5, 1'b1, 3'd0, 1'b0, 3'd5, 1'b0), 2'b00, 1'b0, 1'b0, 1'b0, 1, 1);
      step(0, mk(4'b0000, 1'b0, 2'b00, 3'd0, 1'b1, 3'd6, 1'b1, 3'd6, 1'b1), 2'b10, 1'b1, 1'b1, 1'b0, 1, 1);
      step(0, mk(4'b0010, 1'b0, 2'b11, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0), 2'b01, 1'b0, 1'b0, 1'b1, 2, 1);
      step(0, mk(4'b1000, 1'b0, 2'b10, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0), 2'b01, 1'b0, 1'b0, 1'b1, 2, 2);
      step(0, mk(4'b1110, 1'b0, 2'b01, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0), 2'b00, 1'b0, 1'b0, 1'b0, 2, 3);
      step(0, mk(4'b0001, 1'b0, 2'b10, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0), 2'b00, 1'b0, 1'b0, 1'b0, 2, 3);
      step(0, idle, 2'b00, 1'b0, 1'b0, 1'b0, 2, 3);
      in_a = idle;

      // DUT B: two-cycle flush window, then three-cycle stalls with saturation
      step(1, mk(4'b0001, 1'b0, 2'b01, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0), 2'b01, 1'b0, 1'b0, 1'b1, 0, 0);
      step(1, mk(4'b0000, 1'b1, 2'b00, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1), 2'b00, 1'b0, 1'b0, 1'b1, 0, 1);
      step(1, mk(4'b0001, 1'b0, 2'b10, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0), 2'b00, 1'b0, 1'b0, 1'b0, 0, 1);
      step(1, lu_b, 2'b10, 1'b1, 1'b1, 1'b0, 0, 1);
      step(1, lu_b, 2'b10, 1'b1, 1'b1, 1'b0, 1, 1);
      step(1, lu_b, 2'b10, 1'b1, 1'b1, 1'b0, 2, 1);
      step(1, idle, 2'b00, 1'b0, 1'b0, 1'b0, 3, 1);
      step(1, lu_b, 2'b10, 1'b1, 1'b1, 1'b0, 3, 1);
      step(1, lu_b, 2'b10, 1'b1, 1'b1, 1'b0, 3, 1);
      step(1, lu_b, 2'b10, 1'b1, 1'b1, 1'b0, 3, 1);
      step(1, idle, 2'b00, 1'b0, 1'b0, 1'b0, 3, 1);
      // Reset dropped in the second stall cycle.
      step(1, lu_b, 2'b10, 1'b1, 1'b1, 1'b0, 3, 1);
      drive(1, lu_b, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);
      #2;
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      step(1, idle, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1, idle, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);

      // DUT C: 2-bit counters saturate; jumps under load-use are not counted
      for (int i = 0; i < 5; i++) begin
         step(2, lu_c, 2'b10, 1'b1, 1'b1, 1'b0, (i < 3) ? i : 3, 0);
      end
      step(2, idle, 2'b00, 1'b0, 1'b0, 1'b0, 3, 0);
      for (int i = 0; i < 5; i++) begin
         step(2, mk(4'b0000, 1'b1, 2'b00, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0),
              2'b01, 1'b0, 1'b0, 1'b1, 3, (i < 3) ? i : 3);
      end
      step(2, idle, 2'b00, 1'b0, 1'b0, 1'b0, 3, 3);

      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         tick();
      end
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         $display("FAIL dut%0d step%0d: never compared, monitor got no cycle", e.dut, e.tag);
      end
      $display("%0d/%0d checks passed", passed, checks);
      if (passed == checks) begin
         $display("PASS");
      end else begin
         $display("FAIL");
      end
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised, stateful successor to the combinational hazard detector. Sits beside the decode stage and drives PC select, pipeline-register hold/flush and ID/EX bubble. It supports multi-cycle load-use stalls, multi-cycle branch flush windows, per-source valid qualification and saturating stall/flush event counters.

Parameters:
REG_W, 3, register address width
CCR_W, 4, flag register width; bit map [3]=N, [2]=O, [1]=C, [0]=Z
LOAD_STALL_CYCLES, 1, bubbles per load-use hazard (>=1)
FLUSH_CYCLES, 1, cycles flushF is held after a taken branch (>=1)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ccr  in  CCR_W  current flags
jmpUncond  in  1  decode instruction is JMP
jmpCond  in  2  decode conditional jump: 00 none, 01 JZ, 10 JN, 11 JC
src1  in  REG_W  decode source 1
src1Valid  in  1  src1 is read
src2  in  REG_W  decode source 2
src2Valid  in  1  src2 is read
exDst  in  REG_W  ID/EX destination
exMemRead  in  1  ID/EX instruction loads (LDD/POP)
pcSrc  out  2  00 PC+1, 01 jump target, 10 hold PC
stallD  out  1  hold IF/ID register
bubbleE  out  1  force NOP into ID/EX
flushF  out  1  clear IF/ID register
stallCount  out  CNT_W  load-use stall cycles seen
flushCount  out  CNT_W  taken jumps seen

Behaviour:
- Outputs are combinational from state and inputs. While rst=0: pcSrc=00, all 1-bit outputs 0, counters 0, state RUN.
- loadUse = exMemRead & ((src1Valid & src1==exDst) | (src2Valid & src2==exDst)).
- condTaken = (jmpCond==01 & ccr[0]) | (jmpCond==10 & ccr[3]) | (jmpCond==11 & ccr[1]).
- taken = jmpUncond | condTaken.
- FSM states: RUN, STALL, FLUSH. A down-counter cnt (width ceil(log2(max(LOAD_STALL_CYCLES, FLUSH_CYCLES)))+1) runs in STALL and FLUSH.
- RUN, loadUse=1:
  - pcSrc=10, stallD=1, bubbleE=1.
  - If LOAD_STALL_CYCLES>1, go to STALL with cnt=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  - Any jump is ignored this cycle. Load-use has priority because operands and flags are not final.
- RUN, loadUse=0, taken=1:
  - pcSrc=01, flushF=1.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
- RUN, neither condition: pcSrc=00, all other outputs 0.
- STALL:
  - pcSrc=10, stallD=1, bubbleE=1 unconditionally. New hazards and jumps are ignored, since the decode instruction is held and re-evaluated on return to RUN.
  - cnt decrements each cycle; on cnt==1 go to RUN.
- FLUSH:
  - pcSrc=00, flushF=1. Decode contents are invalid, so loadUse and taken are ignored.
  - cnt decrements; on cnt==1 go to RUN.
- stallCount increments once per cycle that bubbleE=1.
- flushCount increments once per taken jump accepted in RUN, not per flush cycle.
- Both counters saturate at all-ones and never wrap.
- exMemRead=0 never stalls, even on an address match. An invalid source never matches.
- Reset asserted mid-STALL or mid-FLUSH aborts immediately to RUN with zero outputs.

Test Plan:
- Defaults; exMemRead=1, exDst=3, src1=3, src1Valid=1, jmpUncond=1 -> one cycle pcSrc=10, stallD=1, bubbleE=1, flushF=0; stallCount=1, flushCount=0.
- Same stimulus with src1Valid=0, src2=3, src2Valid=0 -> no stall; jump taken, pcSrc=01, flushF=1; flushCount=1.
- LOAD_STALL_CYCLES=3, load-use held -> exactly 3 cycles pcSrc=10/bubbleE=1, then RUN and re-evaluation; stallCount=3.
- FLUSH_CYCLES=2; jmpCond=01, ccr=0001 -> pcSrc=01 and flushF=1 for cycle 0, flushF=1 for cycle 1, a jump presented in cycle 1 is ignored; jmpCond=10, ccr=0001 -> not taken, pcSrc=00.
- CNT_W=2, 5 consecutive single-cycle stalls -> stallCount ends at 3, not wrapped.
- rst pulled low during STALL cycle 2 of 3 -> outputs and counters 0 asynchronously; after release, state RUN with no residual stall.
